// File: rtl/fetch_buffer_if.sv
// Fetch-stage bundle: PC/advance with the program counter, instruction-memory
// handshake, and the decode-side queue head.
interface fetch_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32,
  parameter int unsigned AW    = 64
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] PC;
  logic          advance;
  logic          flush;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_instr;
  logic [CW-1:0] occupancy;

  modport master (
    input  PC, flush, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output advance, imem_req, imem_addr, out_valid, out_pc, out_instr, occupancy
  );

  modport slave (
    output PC, flush, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  advance, imem_req, imem_addr, out_valid, out_pc, out_instr, occupancy
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: one outstanding single-beat read, results queued
// as {pc, instr} for decode; flush discards queued and in-flight fetches.
module fetch_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32,
  parameter int unsigned AW    = 64
) (
  input logic           clock,
  input logic           reset,
  fetch_buffer_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  logic          drop;
  logic [AW-1:0] req_pc;
  logic [AW-1:0] pc_mem  [DEPTH];
  logic [IW-1:0] ins_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          has_room;

  // Request is gated by reset so the bus is quiet while the block is held.
  always_comb begin
    has_room      = count < CW'(DEPTH);
    bus.imem_req  = reset && (state == S_IDLE) && !bus.flush && has_room;
    bus.advance   = bus.imem_req && bus.imem_gnt;
    bus.imem_addr = bus.PC;
    bus.out_valid = (count != '0);
    bus.occupancy = count;
    bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr]  : '0;
    bus.out_instr = bus.out_valid ? ins_mem[rd_ptr] : '0;
    pop           = bus.out_valid && bus.out_ready && !bus.flush;
    push          = (state == S_WAIT) && bus.imem_rvalid && !drop && !bus.flush;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]  <= req_pc;
      ins_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      drop   <= 1'b0;
      req_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // A read still in flight is marked so its late response is discarded.
      if (state == S_WAIT) begin
        if (bus.imem_rvalid) begin
          state <= S_IDLE;
          drop  <= 1'b0;
        end else begin
          drop  <= 1'b1;
        end
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      case (state)
        S_IDLE: begin
          if (bus.advance) begin
            req_pc <= bus.PC;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            drop  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Takes the current PC, issues single-beat reads to instruction memory over a req/gnt/rvalid handshake, and requests PC advance (PS=01) on each accepted read.
- Queues {pc, instruction} pairs in a small FIFO for the decode stage.
- Flush discards queued and in-flight fetches on branch redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- IW, 32, instruction width in bits.
- AW, 64, address/PC width in bits.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- PC  in  AW  current fetch address from the program counter
- advance  out  1  pulse; control drives PS=01 this cycle so PC<=PC4 at the next edge
- flush  in  1  redirect; discard all queued and in-flight fetches
- imem_req  out  1  read request valid
- imem_addr  out  AW  read address; equals PC
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  IW  instruction word
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode consumes the head
- out_pc  out  AW  PC of the head entry
- out_instr  out  IW  instruction at the head entry
- occupancy  out  log2(DEPTH)+1  entries currently held

Behaviour:
- Reset (reset=0, async):
  - FIFO empty, state IDLE, drop=0.
  - occupancy=0, out_valid=0, out_pc=0, out_instr=0.
  - imem_req=0, advance=0.
- States:
  - IDLE: no read outstanding.
  - WAIT: one read granted, response pending.
  - At most one outstanding read.
- IDLE:
  - imem_req = !flush && (occupancy + 0) < DEPTH.
  - imem_addr = PC, combinational.
  - When imem_req && imem_gnt: advance=1 in the same cycle; latch req_pc<=PC; go to WAIT.
  - advance is never 1 without a grant.
- WAIT:
  - imem_req=0.
  - On imem_rvalid:
    - If drop=0 and flush=0: push {req_pc, imem_rdata}.
    - Otherwise discard the response.
    - In both cases clear drop and go to IDLE.
  - rvalid in IDLE is ignored.
- Slot reservation:
  - Issue requires occupancy + (state==WAIT) < DEPTH.
  - A push therefore never meets a full FIFO.
  - Since issue only happens in IDLE, the effective test is occupancy < DEPTH.
- Pop: out_valid && out_ready removes the head.
- Push and pop in the same cycle: occupancy unchanged, ordering preserved.
- Output: out_valid = (occupancy != 0); out_pc and out_instr show the head entry, held stable while out_valid && !out_ready.
- Flush (sampled at the rising edge):
  - FIFO cleared; occupancy=0 the next cycle.
  - Pop and push in the flush cycle are ignored.
  - If in WAIT with no rvalid that cycle, set drop=1 so the late response is discarded.
  - imem_req=0 and advance=0 during the flush cycle.
  - Fetching resumes the next cycle from the redirected PC.
- Latency:
  - Grant at cycle N, rvalid at N+k (k>=1).
  - Entry visible (out_valid=1) at N+k+1.
  - Back-to-back fetch with k=1: one instruction per 2 cycles.
- Ordering: entries leave in fetch order; out_pc equals the PC sampled at grant.
- Reset mid-WAIT: in-flight response is lost and drop is cleared. Memory must be reset together with this block.

Test Plan:
- Reset released, PC=0x0, gnt=1, 1-cycle memory returning 0xF8000001, 0xF8000002 -> advance pulses at cycles 0 and 2; out_valid rises at cycle 2 with out_pc=0x0, out_instr=0xF8000001, then out_pc=0x4.
- out_ready=0, continuous grants -> exactly 4 entries (PC 0x0, 0x4, 0x8, 0xC); occupancy=4; imem_req=0, advance=0 while full. One pop -> a new request with PC=0x10 in the next cycle.
- Flush while in WAIT with 2 entries queued; rvalid arrives 3 cycles later with 0xDEADBEEF -> occupancy=0 after the flush edge; late response dropped; out_valid stays 0 until a fresh fetch from the new PC=0x400 returns.
- Flush asserted in the same cycle as rvalid -> response discarded, state IDLE, occupancy=0, no advance that cycle.
- Simultaneous push and pop at occupancy=2 -> occupancy stays 2, next out_pc is the older entry.
- reset driven low mid-WAIT with 3 entries queued -> outputs immediately 0 (async), occupancy=0, imem_req=0; after release, the first request uses the current PC.
